// File: rtl/shape_row_reader_pkg.sv
// rtl/shape_row_reader_pkg.sv - shared constants, shape id type and FSM encoding for the shape row reader
package shape_row_reader_pkg;

  localparam int SHAPE_ROW_W  = 51;
  localparam int SHAPE_ROWS   = 60;
  localparam int SHAPE_ADDR_W = 6;
  localparam int SHAPE_X_W    = 6;

  typedef logic [1:0] shape_id_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

endpackage

// File: rtl/shape_row_reader_serializer.sv
// rtl/shape_row_reader_serializer.sv - row load/shift register with column counter and valid/ready hold
module shape_row_serializer #(
  parameter int W   = 51,
  parameter int X_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_load,
  input  logic [W-1:0]   i_load_data,
  input  logic           i_ready,
  output logic           o_valid,
  output logic           o_data,
  output logic [X_W-1:0] o_x,
  output logic           o_row_end
);

  localparam logic [X_W-1:0] LAST_COL = X_W'(W - 1);

  logic [W-1:0]   r_shift;
  logic [X_W-1:0] r_col;
  logic           r_valid;
  logic           w_xfer;

  assign w_xfer    = r_valid & i_ready;
  assign o_row_end = w_xfer & (r_col == LAST_COL);
  assign o_valid   = r_valid;
  // Gate data with valid so the stream reads 0 whenever nothing is being offered.
  assign o_data    = r_valid & r_shift[W-1];
  assign o_x       = r_col;

  // Load a row, then advance one pixel per accepted transfer; drop valid after the last column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_load_data;
      r_col   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      if (r_col == LAST_COL) begin
        r_valid <= 1'b0;
      end else begin
        r_shift <= {r_shift[W-2:0], 1'b0};
        r_col   <= r_col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shape_row_reader.sv
// rtl/shape_row_reader.sv - walks the rows of one shape ROM image and streams its pixels with x/y coordinates
module shape_row_reader
  import shape_row_reader_pkg::*;
#(
  parameter int ROW_W  = SHAPE_ROW_W,
  parameter int ROWS   = SHAPE_ROWS,
  parameter int ADDR_W = SHAPE_ADDR_W,
  parameter int X_W    = SHAPE_X_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [1:0]        i_shape_sel,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_rom_dataret,
  output logic [ADDR_W-1:0] o_rom_address,
  input  logic [ROW_W-1:0]  i_rom_outdata,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic              o_pix_data,
  output logic [X_W-1:0]    o_pix_x,
  output logic [ADDR_W-1:0] o_pix_y,
  output logic              o_pix_last
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  localparam logic [X_W-1:0]    LAST_COL = X_W'(ROW_W - 1);

  state_t            r_state;
  logic              r_busy;
  logic              r_done;
  shape_id_t         r_shape;
  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_rom_address;
  logic              w_load;
  logic              w_row_end;
  logic              w_valid;
  logic [X_W-1:0]    w_x;

  assign w_load = (r_state == ST_LOAD);

  shape_row_serializer #(
    .W   (ROW_W),
    .X_W (X_W)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_data (i_rom_outdata),
    .i_ready     (i_pix_ready),
    .o_valid     (w_valid),
    .o_data      (o_pix_data),
    .o_x         (w_x),
    .o_row_end   (w_row_end)
  );

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_rom_dataret = r_shape;
  assign o_rom_address = r_rom_address;
  assign o_pix_valid   = w_valid;
  assign o_pix_x       = w_x;
  assign o_pix_y       = r_row;
  assign o_pix_last    = w_valid & (w_x == LAST_COL) & (r_row == LAST_ROW);

  // Frame sequencer: address is set up one state ahead so the ROM sees it during FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_shape       <= '0;
      r_row         <= '0;
      r_rom_address <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_shape       <= i_shape_sel;
            r_row         <= '0;
            r_rom_address <= '0;
            r_busy        <= 1'b1;
            r_state       <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD:  r_state <= ST_SHIFT;
        ST_SHIFT: begin
          if (w_row_end) begin
            if (r_row == LAST_ROW) begin
              r_done  <= 1'b1;
              r_state <= ST_FIN;
            end else begin
              r_row         <= r_row + 1'b1;
              r_rom_address <= r_row + 1'b1;
              r_state       <= ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_row_reader.sv
// tb/tb_shape_row_reader.sv - scoreboard bench for shape_row_reader
module tb_shape_row_reader;
  import shape_row_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [1:0]  i_shape_sel = 2'd0;
  logic        i_pix_ready = 1'b0;
  logic [50:0] i_rom_outdata;
  logic        o_busy, o_done, o_pix_valid, o_pix_data, o_pix_last;
  logic [1:0]  o_rom_dataret;
  logic [5:0]  o_rom_address, o_pix_x, o_pix_y;

  shape_row_reader dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_shape_sel(i_shape_sel),
    .o_busy(o_busy), .o_done(o_done), .o_rom_dataret(o_rom_dataret),
    .o_rom_address(o_rom_address), .i_rom_outdata(i_rom_outdata),
    .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready), .o_pix_data(o_pix_data),
    .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_pix_last(o_pix_last)
  );

  always #5 clk = ~clk;

  function automatic logic [50:0] rom_img(input logic [1:0] s, input logic [5:0] r);
    logic [50:0] v;
    v = '0;
    if (r < 6'd60) begin
      if (s == 2'd0) begin
        if (r == 6'd0)       v = 51'h0000002000000;
        else if (r == 6'd37) v = '1;
        else                 v = 51'h5A5A5A5A5A5A5 ^ ({45'd0, r} << r);
      end else if (s == 2'd1) begin
        if (r == 6'd30) v = 51'h7FFFC0003FFFF;
        else            v = 51'h3C3C3C3C3C3C3 ^ {45'd0, r};
      end
    end
    return v;
  endfunction

  logic [1:0] rom_sel_q = 2'd0;
  logic [5:0] rom_addr_q = 6'd0;
  always @(posedge clk) begin
    rom_sel_q  <= o_rom_dataret;
    rom_addr_q <= o_rom_address;
  end
  assign i_rom_outdata = rom_img(rom_sel_q, rom_addr_q);

  typedef struct packed {
    logic [5:0] x;
    logic [5:0] y;
    logic       d;
    logic       l;
  } pix_t;

  pix_t        exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          n_xfer = 0;
  bit          rnd_ready = 1'b0;
  logic [50:0] cap [60];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  task automatic push_frame(input logic [1:0] s);
    pix_t        e;
    logic [50:0] v;
    for (int y = 0; y < 60; y++) begin
      v = rom_img(s, 6'(y));
      for (int x = 0; x < 51; x++) begin
        e.x = 6'(x);
        e.y = 6'(y);
        e.d = v[50 - x];
        e.l = (x == 50) && (y == 59);
        exp_q.push_back(e);
      end
    end
  endtask

  // Ready driver: constant 1 or 50% random, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1 i_pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard compare, hold-while-stalled, inter-row gap and done timing.
  initial begin
    pix_t cur, prev, e;
    bit   prev_stall, done_due;
    int   gap;
    prev_stall = 0; done_due = 0; gap = 0; prev = '0;
    forever begin
      @(negedge clk);
      cur = '{x: o_pix_x, y: o_pix_y, d: o_pix_data, l: o_pix_last};
      if (rst) begin
        prev_stall = 0; done_due = 0; gap = 0;
      end else begin
        if (done_due || o_done)
          check(o_done == done_due, "done_timing", 64'(o_done), 64'(done_due));
        done_due = 0;
        if (prev_stall)
          check(o_pix_valid && cur == prev, "hold_stall", 64'({o_pix_valid, cur}), 64'({1'b1, prev}));
        if (o_pix_valid && i_pix_ready) begin
          n_xfer++;
          if (cur.x == 6'd0 && cur.y != 6'd0)
            check(gap == 2, "row_gap", 64'(gap), 64'd2);
          gap = 0;
          if (cur.y < 6'd60 && cur.x < 6'd51) cap[cur.y][50 - cur.x] = cur.d;
          if (exp_q.size() == 0) begin
            check(1'b0, "extra_xfer", 64'(cur), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check(cur == e, "pixel", 64'(cur), 64'(e));
            done_due = e.l;
          end
        end else if (!o_pix_valid) begin
          gap++;
        end
        prev_stall = o_pix_valid && !i_pix_ready;
        prev = cur;
      end
    end
  end

  task automatic run_frame(input logic [1:0] s, input bit rnd, input bit extra_start);
    int  n;
    bit  seen;
    rnd_ready = rnd;
    n_xfer = 0;
    for (int y = 0; y < 60; y++) cap[y] = '1;
    push_frame(s);
    @(posedge clk);
    #1 i_shape_sel = s; i_start = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      if (n == 0) begin
        i_start = 1'b0;
        check(o_busy == 1'b1, "busy_after_start", 64'(o_busy), 64'd1);
      end
      n++;
    end while (!o_pix_valid && n < 10);
    check(n == 3, "first_valid_latency", 64'(n), 64'd3);
    seen = 0;
    for (int c = 0; c < 20000 && !seen; c++) begin
      if (o_done) seen = 1;
      else begin
        if (extra_start && c == 1000) begin i_shape_sel = 2'd0; i_start = 1'b1; end
        else i_start = 1'b0;
        @(posedge clk); #1;
      end
    end
    i_start = 1'b0;
    check(seen, "done_seen", 64'(seen), 64'd1);
    check(n_xfer == 3060, "xfer_count", 64'(n_xfer), 64'd3060);
    check(exp_q.size() == 0, "queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    check(o_busy == 1'b0, "busy_cleared", 64'(o_busy), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [50:0] acc;
    bit          hit;
    repeat (3) @(posedge clk);
    #1;
    check(!o_busy && !o_done && !o_pix_valid && !o_pix_data && !o_pix_last, "reset_flags",
          64'({o_busy, o_done, o_pix_valid, o_pix_data, o_pix_last}), 64'd0);
    check(o_pix_x == 0 && o_pix_y == 0, "reset_xy", 64'({o_pix_x, o_pix_y}), 64'd0);
    check(o_rom_address == 0 && o_rom_dataret == 0, "reset_rom", 64'({o_rom_dataret, o_rom_address}), 64'd0);
    rst = 1'b0;

    run_frame(2'd0, 1'b0, 1'b0);
    check(cap[0] == 51'h0000002000000, "s0_row0_only_x25", 64'(cap[0]), 64'h2000000);
    check(cap[37] == {51{1'b1}}, "s0_row37_all_ones", 64'(cap[37]), 64'h7FFFFFFFFFFFF);

    run_frame(2'd1, 1'b0, 1'b0);
    check(cap[30] == 51'h7FFFC0003FFFF, "s1_row30", 64'(cap[30]), 64'h7FFFC0003FFFF);

    run_frame(2'd1, 1'b1, 1'b0);

    run_frame(2'd2, 1'b1, 1'b1);
    acc = '0;
    for (int y = 0; y < 60; y++) acc = acc | cap[y];
    check(acc == '0, "s2_all_zero", 64'(acc), 64'd0);

    rnd_ready = 1'b0;
    push_frame(2'd0);
    @(posedge clk);
    #1 i_shape_sel = 2'd0; i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    hit = 0;
    for (int c = 0; c < 5000 && !hit; c++) begin
      if (o_pix_valid && o_pix_y == 6'd20 && o_pix_x == 6'd10) hit = 1;
      else begin @(posedge clk); #1; end
    end
    check(hit, "reached_row20_col10", 64'(hit), 64'd1);
    rst = 1'b1;
    #1;
    check(!o_busy && !o_pix_valid && o_rom_address == 0 && !o_done, "abort_outputs",
          64'({o_busy, o_pix_valid, o_done, o_rom_address}), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check(!o_busy && !o_done, "idle_after_abort", 64'({o_busy, o_done}), 64'd0);

    run_frame(2'd0, 1'b0, 1'b0);
    check(cap[0] == 51'h0000002000000, "replay_row0", 64'(cap[0]), 64'h2000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
